// File: rtl/decoder2to4_pkg.sv
// decoder2to4_pkg: shared state encoding, widths and one-hot helper for the strobe decoder.
package decoder2to4_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} state_t;
  localparam int CODE_W = 2;
  localparam int OUT_W = 4;
  localparam int CNT_W = 8;
  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] c);
    return OUT_W'(1) << c;
  endfunction
endpackage

// File: rtl/decoder2to4_strobe_fifo2.sv
// fifo2: 2-entry synchronous FIFO; push/pop ignored when full/empty respectively.
module fifo2
  import decoder2to4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [CODE_W-1:0] head
);
  logic [CODE_W-1:0] mem_q [2];
  logic [CODE_W-1:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic wr_en, rd_en;
  assign full = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign head = mem_q[rd_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q] = din;
    wr_d = wr_en ? ~wr_q : wr_q;
    rd_d = rd_en ? ~rd_q : rd_q;
    cnt_d = cnt_q + {1'b0, wr_en} - {1'b0, rd_en};
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/decoder2to4_strobe.sv
// decoder2to4_strobe: buffered 2-to-4 decoder emitting timed one-hot strobes with idle gaps.
module decoder2to4_strobe
  import decoder2to4_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
);
  if (PULSE_LEN < 1 || PULSE_LEN > 255 || GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_param
    $error("decoder2to4_strobe: PULSE_LEN must be 1..255 and GAP_LEN 0..255");
  end
  localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP_LEN - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic done_q, done_d;
  logic full, empty, pop;
  logic [CODE_W-1:0] head;
  fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .push(in_valid & ~full),
    .pop(pop),
    .din(code),
    .full(full),
    .empty(empty),
    .head(head)
  );
  assign in_ready = ~full;
  assign y = y_q;
  assign done = done_q;
  assign busy = (state_q != IDLE) | ~empty;
  // IDLE and an expired PULSE/GAP counter share one decision point: gap, load, or idle.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    y_d = y_q;
    done_d = 1'b0;
    pop = 1'b0;
    if (state_q != IDLE && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    else begin
      done_d = state_q == PULSE;
      if (state_q == PULSE && GAP_LEN != 0) begin
        state_d = GAP;
        cnt_d = GAP_M1;
        y_d = '0;
      end else if (~empty & en) begin
        pop = 1'b1;
        state_d = PULSE;
        cnt_d = PULSE_M1;
        y_d = onehot(head);
      end else begin
        state_d = IDLE;
        y_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_decoder2to4_strobe.sv
// tb_decoder2to4_strobe: two DUTs (GAP_LEN 1 and 0) against a behavioural model plus directed literal checks.
module tb_decoder2to4_strobe;
  localparam int PL = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] code = 2'd0;
  logic en = 1'b1;
  logic ready_a, busy_a, done_a, ready_b, busy_b, done_b;
  logic [3:0] y_a, y_b;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  always #5 clk = ~clk;

  decoder2to4_strobe #(.PULSE_LEN(PL), .GAP_LEN(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a), .code(code),
    .en(en), .y(y_a), .busy(busy_a), .done(done_a)
  );
  decoder2to4_strobe #(.PULSE_LEN(PL), .GAP_LEN(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b), .code(code),
    .en(en), .y(y_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle / 1 pulse / 2 gap, with cycles left in the phase and a plain code buffer.
  int glen [2] = '{1, 0};
  int ph [2], left [2], cur [2], n [2], dn [2];
  int fb [2][2];
  bit m_ready, m_push, m_can, m_load;
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        n[m] = 0; ph[m] = 0; left[m] = 0; dn[m] = 0;
      end else begin
        m_ready = n[m] < 2;
        m_push = in_valid && m_ready;
        m_can = n[m] > 0 && en;
        m_load = 1'b0;
        dn[m] = 0;
        if (ph[m] == 1) begin
          if (left[m] > 1) left[m]--;
          else begin
            dn[m] = 1;
            if (glen[m] > 0) begin ph[m] = 2; left[m] = glen[m]; end
            else if (m_can) m_load = 1'b1;
            else ph[m] = 0;
          end
        end else if (ph[m] == 2) begin
          if (left[m] > 1) left[m]--;
          else if (m_can) m_load = 1'b1;
          else ph[m] = 0;
        end else if (m_can) m_load = 1'b1;
        if (m_load) begin
          cur[m] = fb[m][0]; fb[m][0] = fb[m][1]; n[m]--; ph[m] = 1; left[m] = PL;
        end
        if (m_push) begin fb[m][n[m]] = int'(code); n[m]++; end
      end
    end
  end

  function automatic logic [3:0] m_y(input int m);
    return (ph[m] == 1) ? 4'(1 << cur[m]) : 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("model_y_a", y_a, m_y(0));
      chk("model_done_a", done_a, dn[0]);
      chk("model_busy_a", busy_a, ph[0] != 0 || n[0] > 0);
      chk("model_ready_a", ready_a, n[0] < 2);
      chk("model_y_b", y_b, m_y(1));
      chk("model_done_b", done_b, dn[1]);
      chk("model_busy_b", busy_b, ph[1] != 0 || n[1] > 0);
      chk("model_ready_b", ready_b, n[1] < 2);
    end
  end

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0] seq_a [14] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                             4'h4, 4'h4, 4'h4, 4'h4};
  logic [3:0] seq_b [12] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4,
                             4'h4, 4'h4};

  initial begin
    step();
    armed = 1'b1;
    chk("reset_y", y_a, 4'h0);
    chk("reset_ready", ready_a, 1);
    chk("reset_busy", busy_a, 0);
    step();
    rst = 1'b0;
    // single code 3
    in_valid = 1'b1; code = 2'd3;
    step();
    in_valid = 1'b0;
    chk("single_y_k", y_a, 4'h0);
    chk("single_busy_k", busy_a, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_y_pulse", y_a, 4'h8);
      chk("single_done_pulse", done_a, 0);
    end
    step();
    chk("single_y_end", y_a, 4'h0);
    chk("single_done_end", done_a, 1);
    step();
    chk("single_done_once", done_a, 0);
    step(3);
    // back-to-back 0,1,2
    in_valid = 1'b1; code = 2'd0;
    step();
    code = 2'd1;
    step();
    chk("b2b_y_a", y_a, seq_a[0]);
    chk("b2b_y_b", y_b, seq_b[0]);
    code = 2'd2;
    step();
    in_valid = 1'b0;
    chk("b2b_full_ready", ready_a, 0);
    for (int i = 1; i < 14; i++) begin
      chk("b2b_y_a", y_a, seq_a[i]);
      if (i < 12) chk("b2b_y_b", y_b, seq_b[i]);
      if (i == 4) chk("gap0_done_b", done_b, 1);
      step();
    end
    step(8);
    // en gating
    en = 1'b0; in_valid = 1'b1; code = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    chk("en_hold_y", y_a, 4'h0);
    chk("en_hold_busy", busy_a, 1);
    en = 1'b1;
    step();
    chk("en_raise_y", y_a, 4'h2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_drop_y", y_a, 4'h2);
    end
    step();
    chk("en_drop_end", y_a, 4'h0);
    en = 1'b1;
    step(4);
    // full buffer with simultaneous pop
    en = 1'b0; in_valid = 1'b1; code = 2'd0;
    step();
    code = 2'd2;
    step();
    code = 2'd3; en = 1'b1;
    chk("full_pop_ready_pre", ready_a, 0);
    step();
    chk("full_pop_ready_post", ready_a, 1);
    step();
    in_valid = 1'b0;
    chk("full_pop_accepted", ready_a, 0);
    step(30);
    // reset mid-strobe (cycle 2 of 4)
    in_valid = 1'b1; code = 2'd2;
    step();
    in_valid = 1'b0;
    step(2);
    chk("rst_pre_y", y_a, 4'h4);
    rst = 1'b1;
    step();
    chk("rst_y", y_a, 4'h0);
    chk("rst_done", done_a, 0);
    chk("rst_ready", ready_a, 1);
    chk("rst_busy", busy_a, 0);
    step();
    rst = 1'b0;
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      code = 2'($urandom_range(0, 3));
      en = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    in_valid = 1'b0; rst = 1'b0; en = 1'b1;
    step(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder2to4_strobe.md
# decoder2to4_strobe

Clocked 2-to-4 decoder, the inverse of the team's 4-to-2 encoder. It accepts 2-bit codes over a valid/ready handshake into a 2-entry buffer and drives the matching one-hot output for a programmable number of cycles. A programmable idle gap follows each strobe. It sits downstream of the encoder path to regenerate one-hot strobes (select lines, LED/row drive) from binary indices.

## Interface
- PULSE_LEN, default 4: cycles each one-hot strobe is held; legal 1..255.
- GAP_LEN, default 1: cycles y is held at 0 between strobes; legal 0..255.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  code is valid this cycle.
- in_ready  output  1  buffer can accept; equals (buffer count < 2).
- code  input  2  binary index to decode; sampled when in_valid & in_ready.
- en  input  1  permits starting a new strobe; does not abort one in progress.
- y  output  4  registered one-hot output (1 << code) or 4'b0000.
- busy  output  1  high in PULSE or GAP, or when the buffer is non-empty.
- done  output  1  one-cycle pulse in the first cycle after a strobe ends.

## Operation
- Buffer: 2-entry FIFO; push on in_valid & in_ready; pop only when the FSM loads a strobe.
- in_ready is computed from the current count only. A push is refused when full, even if a pop occurs in the same cycle.
- FSM states: IDLE, PULSE, GAP.
- IDLE: y=0. If the buffer is non-empty and en=1, pop and load y <= 1<<head, cnt <= PULSE_LEN-1, then go to PULSE.
- PULSE: y held. If cnt != 0, decrement. If cnt == 0, assert done next cycle and end the strobe:
  - GAP_LEN > 0: y <= 0, cnt <= GAP_LEN-1, go to GAP.
  - GAP_LEN = 0: if buffer non-empty and en=1, load the next strobe directly (y switches one-hot to one-hot); otherwise y <= 0 and go to IDLE.
- GAP: y=0. If cnt != 0, decrement. If cnt == 0, apply the IDLE load rule in the same edge (load, else go to IDLE).
- en low never truncates PULSE or GAP. It only blocks loads; the buffer keeps its codes.
- cnt is 8 bits wide. Illegal parameter values (PULSE_LEN=0, or either value >255) are a parameter error, checked at elaboration.

## Timing
- Reset values: y=0, done=0, busy=0, in_ready=1, state=IDLE, buffer empty, cnt=0.
- rst mid-operation: all of the above take effect at the next edge. Any strobe is cut and buffered codes are flushed.
- Latency: code accepted at edge k, FSM in IDLE with empty buffer and en=1 → y valid after edge k+1.
- y is high for exactly PULSE_LEN cycles per code, then low for exactly GAP_LEN cycles when the next code is already buffered.
- done is high for one cycle, coincident with the first cycle after the strobe. With GAP_LEN=0 and back-to-back codes, this is the first cycle of the next strobe.
- busy is registered-state derived, with no combinational path from inputs.

## Structure
- Shared package/header decoder2to4_pkg holds:
  - state encoding IDLE=2'd0, PULSE=2'd1, GAP=2'd2;
  - CODE_W=2 and OUT_W=4;
  - the count width CNT_W=8.
- One sub-module, fifo2: a 2-entry synchronous FIFO with push/pop/full/empty/head and the same clk/rst. The FSM and decode live in the top.

## Test plan
- Reset: hold rst 2 cycles mid-strobe (code=2, cycle 2 of 4) → next cycle y=0000, done=0, in_ready=1, busy=0.
- Single code with PULSE_LEN=4, GAP_LEN=1: push code=3 at edge k → y=1000 on cycles k+1..k+4, y=0000 at k+5, done=1 at k+5 only.
- Back-to-back: push 0, 1, 2 consecutively →
  - in_ready drops after the third push attempt while full;
  - y sequence 0001×4, 0000×1, 0010×4, 0000×1, 0100×4;
  - all codes delivered in order, none lost.
- GAP_LEN=0: push 1 then 2 → y goes 0010×4 then directly 0100×4; done=1 on the first 0100 cycle.
- en gating:
  - en=0 while code=1 is buffered → y stays 0000, busy=1;
  - raise en → y=0010 on the next cycle;
  - drop en mid-strobe → the strobe still lasts 4 cycles.
- Full with simultaneous pop: buffer full as a strobe loads, in_valid=1 → the push is refused that cycle (in_ready=0) and accepted the following cycle.
